// File: rtl/spin_result_pkg.sv
// Shared types and sizing helpers for the spin result drain controller.
package spin_result_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int SPIN_W_DEF = 50;
  localparam int DEPTH_DEF  = 16;
  localparam int OUT_W_DEF  = 8;

  function automatic int calc_chunks(input int spin_w, input int out_w);
    return (spin_w + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/spin_result_fifo.sv
// Synchronous FIFO with extra pointer wrap bit and a read register updated on pop.
module spin_result_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] dout_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign dout      = dout_r;

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

  // pointers and read register, cleared by reset or soft clear
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      dout_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        dout_r   <= mem_r[rd_ptr_r[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/spin_result_drain_ctrl.sv
// Buffers one spin vector per run and drains them as OUT_W-bit words after the final run.
// Build macro SPIN_RESULT_HDR_EN prefixes each entry with a word holding its index.
module spin_result_drain_ctrl
  import spin_result_pkg::*;
#(
  parameter int SPIN_W = SPIN_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_capture,
  input  logic [SPIN_W-1:0] i_spin,
  input  logic              i_final_run,
  input  logic [7:0]        i_expected_count,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_count,
  output logic              o_busy,
  output logic              o_drain_done,
  output logic              o_overflow
);
  localparam int CHUNKS = calc_chunks(SPIN_W, OUT_W);
  localparam int PAD_W  = CHUNKS * OUT_W;
`ifdef SPIN_RESULT_HDR_EN
  localparam int WORDS  = CHUNKS + 1;
`else
  localparam int WORDS  = CHUNKS;
`endif
  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

  state_t             state_r;
  logic [7:0]         count_r;
  logic [OUT_W-1:0]   data_r;
  logic               valid_r;
  logic               busy_r;
  logic               done_r;
  logic               ovf_r;
  logic [CW-1:0]      word_r;
  logic [PAD_W-1:0]   sh_r;
`ifdef SPIN_RESULT_HDR_EN
  logic [OUT_W-1:0]   idx_r;
`endif

  logic [SPIN_W-1:0]  fifo_dout_s;
  logic [PAD_W-1:0]   pad_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic               start_s;
  logic               hs_s;
  logic               last_s;

  // The pop is issued on entry to LOAD so the head is in the FIFO read register during LOAD.
  spin_result_fifo #(
    .WIDTH (SPIN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (i_clear),
    .push  (push_s),
    .din   (i_spin),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign pad_s = PAD_W'(fifo_dout_s);

  // push/pop decode and drain start condition
  always_comb begin
    push_s  = 1'b0;
    pop_s   = 1'b0;
    start_s = 1'b0;
    hs_s    = valid_r && i_ready;
    last_s  = hs_s && (word_r == LAST_WORD);
    case (state_r)
      COLLECT: begin
        push_s  = i_capture && !fifo_full_s;
        start_s = i_final_run && (count_r == i_expected_count) &&
                  (i_expected_count != 8'd0) && !fifo_empty_s;
        pop_s   = start_s;
      end
      SEND: begin
        pop_s = last_s && !fifo_empty_s;
      end
      default: begin
        push_s  = 1'b0;
        pop_s   = 1'b0;
        start_s = 1'b0;
      end
    endcase
  end

  // control FSM with registered handshake and status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state_r <= COLLECT;
      count_r <= 8'd0;
      data_r  <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      word_r  <= '0;
      sh_r    <= '0;
`ifdef SPIN_RESULT_HDR_EN
      idx_r   <= '0;
`endif
    end else begin
      if (i_capture && ((state_r != COLLECT) || fifo_full_s)) begin
        ovf_r <= 1'b1;
      end
      if (push_s && (count_r != 8'hFF)) begin
        count_r <= count_r + 8'd1;
      end
      case (state_r)
        COLLECT: begin
          if (start_s) begin
            state_r <= LOAD;
            busy_r  <= 1'b1;
          end
        end
        LOAD: begin
          state_r <= SEND;
          word_r  <= '0;
          valid_r <= 1'b1;
`ifdef SPIN_RESULT_HDR_EN
          data_r  <= idx_r;
          sh_r    <= pad_s;
`else
          data_r  <= pad_s[OUT_W-1:0];
          sh_r    <= pad_s >> OUT_W;
`endif
        end
        SEND: begin
          if (last_s) begin
            valid_r <= 1'b0;
`ifdef SPIN_RESULT_HDR_EN
            idx_r   <= idx_r + OUT_W'(1);
`endif
            if (!fifo_empty_s) begin
              state_r <= LOAD;
            end else begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else if (hs_s) begin
            word_r <= word_r + CW'(1);
            data_r <= sh_r[OUT_W-1:0];
            sh_r   <= sh_r >> OUT_W;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= COLLECT;
        end
      endcase
    end
  end

  assign o_data       = data_r;
  assign o_valid      = valid_r;
  assign o_count      = count_r;
  assign o_busy       = busy_r;
  assign o_drain_done = done_r;
  assign o_overflow   = ovf_r;

endmodule
